sdn_parser_action_table: RTL and testbench

Multi-port, parametrised action table for the SDN parser. It holds per-rule action words written by the control path and serves NUM_RD independent lookup channels with a fixed 2-cycle registered read. It adds self-clearing initialisation, soft clear, write-first bypass and out-of-range detection. It sits between the parser match stage and the action engine, one lookup channel per parser lane.

---
 rtl/sdn_parser_action_table.sv | 175 +++++++++++++++++
 tb/tb_sdn_parser_action_table.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdn_parser_action_table.sv
// sdn_parser_action_table
//
// Action table for the SDN parser. The control path writes per-rule action
// words; NUM_RD independent lookup channels read them back with a fixed
// 2-cycle registered latency. After reset, or on a soft clear, the table zeroes
// itself one entry per cycle. A write is visible to a read sampled on the same
// edge. Reads at addresses >= DEPTH are flagged and return zero.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   clr_i            soft clear pulse, honoured only when ready
//   wr_en_i          write request; wr_addr_i / wr_data_i carry address and data
//   wr_drop_o        one-cycle pulse: the previous write request was discarded
//   init_done_o      high once the table is initialised and ready
//   rd_valid_i       per-channel read request; rd_addr_i slice k is channel k
//   rd_valid_o       per-channel response valid; rd_data_o slice k is channel k
//   rd_oor_o         response flag: the request address was >= DEPTH
module sdn_parser_action_table #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic                       wr_drop_o,
  output logic                       init_done_o,
  input  logic [NUM_RD-1:0]          rd_valid_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD-1:0]          rd_valid_o,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_oor_o
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // One extra bit so that DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_drop;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_ready;
  logic w_wr_accept;

  assign w_ready     = (r_state == ST_READY);
  assign w_wr_accept = wr_en_i && w_ready && !clr_i && f_in_range(wr_addr_i);

  // Control FSM, clear counter and write stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_clr_cnt  <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_wr_drop  <= wr_en_i && !w_wr_accept;
      r_wr_valid <= w_wr_accept;
      if (w_wr_accept) begin
        r_wr_addr <= wr_addr_i;
        r_wr_data <= wr_data_i;
      end
      case (r_state)
        ST_INIT: begin
          if (r_clr_cnt == LAST_ADDR) begin
            r_state   <= ST_READY;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          if (clr_i) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Storage is not reset; INIT zeroes it. The write stage is never valid while
  // INIT is writing (writes are dropped in INIT and on the clr_i edge), so the
  // two writers never collide; a write staged just before clr_i commits on the
  // clr_i edge and is overwritten later by the walk.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (r_wr_valid) begin
      r_mem[r_wr_addr] <= r_wr_data;
    end
  end

  assign wr_drop_o   = r_wr_drop;
  assign init_done_o = w_ready;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              r_s1_valid;
    logic              r_s1_init;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              w_s1_in_range;
    logic              w_bypass;
    logic [DATA_W-1:0] w_rdata;
    logic              r_s2_valid;
    logic              r_s2_oor;
    logic [DATA_W-1:0] r_s2_data;

    assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];

    // Stage 1: capture request. Reads issued during INIT are remembered so
    // they return zero regardless of how far the clear walk has got.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s1_valid <= 1'b0;
        r_s1_init  <= 1'b0;
        r_s1_addr  <= '0;
      end else begin
        r_s1_valid <= rd_valid_i[k];
        if (rd_valid_i[k]) begin
          r_s1_addr <= w_addr;
          r_s1_init <= !w_ready;
        end
      end
    end

    assign w_s1_in_range = f_in_range(r_s1_addr);
    // Write-first: the staged write commits on the same edge stage 2 samples.
    assign w_bypass      = r_wr_valid && (r_wr_addr == r_s1_addr);

    always_comb begin
      w_rdata = '0;
      if (w_s1_in_range && !r_s1_init) begin
        w_rdata = w_bypass ? r_wr_data : r_mem[r_s1_addr];
      end
    end

    // Stage 2: register response; data holds while idle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s2_valid <= 1'b0;
        r_s2_oor   <= 1'b0;
        r_s2_data  <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        r_s2_oor   <= r_s1_valid && !w_s1_in_range;
        if (r_s1_valid) begin
          r_s2_data <= w_rdata;
        end
      end
    end

    assign rd_valid_o[k]                 = r_s2_valid;
    assign rd_oor_o[k]                   = r_s2_oor;
    assign rd_data_o[k*DATA_W +: DATA_W] = r_s2_data;
  end

endmodule

// File: tb/tb_sdn_parser_action_table.sv
// Self-checking bench for sdn_parser_action_table (DATA_W=32, ADDR_W=4,
// DEPTH=12, NUM_RD=2). Read expectations go into per-channel queues with the
// cycle they are due; responses are popped and compared as they appear.
module tb_sdn_parser_action_table;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     clr_i = 1'b0;
  logic                     wr_en_i = 1'b0;
  logic [ADDR_W-1:0]        wr_addr_i = '0;
  logic [DATA_W-1:0]        wr_data_i = '0;
  logic                     wr_drop_o;
  logic                     init_done_o;
  logic [NUM_RD-1:0]        rd_valid_i = '0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i = '0;
  logic [NUM_RD-1:0]        rd_valid_o;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_oor_o;

  sdn_parser_action_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .wr_drop_o   (wr_drop_o),
    .init_done_o (init_done_o),
    .rd_valid_i  (rd_valid_i),
    .rd_addr_i   (rd_addr_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .rd_oor_o    (rd_oor_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [1:0]        rv;
    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic              exp_drop;
    logic [DATA_W-1:0] ed0;
    logic [DATA_W-1:0] ed1;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              oor;
    int                due;
  } resp_t;

  resp_t             sb_q [NUM_RD][$];
  logic [DATA_W-1:0] last_d [NUM_RD];
  int                n_cmp = 0;
  int                n_err = 0;
  int                cyc = 0;
  logic              m_ready = 1'b0;
  int                m_cnt = 0;
  vec_t              tbl [18];

  function automatic vec_t mk(input logic clr, input logic we, input logic [ADDR_W-1:0] wa,
                              input logic [DATA_W-1:0] wd, input logic [1:0] rv,
                              input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1,
                              input logic exp_drop, input logic [DATA_W-1:0] ed0,
                              input logic [DATA_W-1:0] ed1);
    vec_t v;
    v.clr = clr; v.we = we; v.wa = wa; v.wd = wd; v.rv = rv;
    v.ra0 = ra0; v.ra1 = ra1; v.exp_drop = exp_drop; v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_reads();
    for (int k = 0; k < NUM_RD; k++) begin
      resp_t             e;
      logic [DATA_W-1:0] d;
      d = rd_data_o[k*DATA_W +: DATA_W];
      if (rd_valid_o[k]) begin
        if (sb_q[k].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_unexpected ch%0d @cyc %0d: got valid=1 data %h, required valid=0",
                   k, cyc, d);
        end else begin
          e = sb_q[k].pop_front();
          chk($sformatf("rd_data ch%0d", k), 64'(d), 64'(e.data));
          chk($sformatf("rd_oor ch%0d", k), 64'(rd_oor_o[k]), 64'(e.oor));
          chk($sformatf("rd_latency ch%0d", k), 64'(cyc), 64'(e.due));
        end
        last_d[k] = d;
      end else begin
        chk($sformatf("rd_oor_idle ch%0d", k), 64'(rd_oor_o[k]), 64'd0);
        chk($sformatf("rd_data_hold ch%0d", k), 64'(d), 64'(last_d[k]));
        if (sb_q[k].size() > 0 && sb_q[k][0].due <= cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_missing ch%0d @cyc %0d: got valid=0, required valid=1 data %h",
                   k, cyc, sb_q[k][0].data);
          void'(sb_q[k].pop_front());
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, model the sampling edge, check at
  // the next falling edge.
  task automatic step(input vec_t v);
    clr_i      = v.clr;
    wr_en_i    = v.we;
    wr_addr_i  = v.wa;
    wr_data_i  = v.wd;
    rd_valid_i = v.rv;
    rd_addr_i  = {v.ra1, v.ra0};
    @(posedge clk);
    if (v.rv[0]) sb_q[0].push_back('{data: v.ed0, oor: (int'(v.ra0) >= DEPTH), due: cyc + 2});
    if (v.rv[1]) sb_q[1].push_back('{data: v.ed1, oor: (int'(v.ra1) >= DEPTH), due: cyc + 2});
    if (m_ready && v.clr) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      if (m_cnt == DEPTH - 1) m_ready = 1'b1;
      else m_cnt++;
    end
    cyc++;
    @(negedge clk);
    clr_i      = 1'b0;
    wr_en_i    = 1'b0;
    rd_valid_i = '0;
    chk("wr_drop", 64'(wr_drop_o), 64'(v.exp_drop));
    chk("init_done", 64'(init_done_o), 64'(m_ready));
    check_reads();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
  endtask

  // Asserted immediately (caller sits at a falling edge) so in-flight reads
  // are caught mid-pipeline.
  task automatic do_reset();
    reset      = 1'b1;
    clr_i      = 1'b0;
    wr_en_i    = 1'b0;
    rd_valid_i = '0;
    #1;
    chk("rst rd_valid", 64'(rd_valid_o), 64'd0);
    chk("rst rd_data", 64'(rd_data_o), 64'd0);
    chk("rst rd_oor", 64'(rd_oor_o), 64'd0);
    chk("rst wr_drop", 64'(wr_drop_o), 64'd0);
    chk("rst init_done", 64'(init_done_o), 64'd0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < NUM_RD; k++) begin
      sb_q[k].delete();
      last_d[k] = '0;
    end
    m_ready = 1'b0;
    m_cnt   = 0;
    reset   = 1'b0;
  endtask

  // INIT walk after reset or clear: reads return zero, OOR still flagged.
  task automatic init_walk();
    for (int a = 0; a < DEPTH; a++) begin
      step(mk(0, 0, 0, 0, 2'b11, ADDR_W'(a), ADDR_W'(a + 4), 0, 0, 0));
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 3,  32'hA5A5_A5A5, 2'b00, 0,  0,  0, 0, 0);
    tbl[1]  = mk(0, 0, 0,  32'h0,         2'b00, 0,  0,  0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  32'h0,         2'b01, 3,  0,  0, 32'hA5A5_A5A5, 0);
    tbl[3]  = mk(0, 1, 5,  32'h1111_1111, 2'b00, 0,  0,  0, 0, 0);
    tbl[4]  = mk(0, 0, 0,  32'h0,         2'b00, 0,  0,  0, 0, 0);
    tbl[5]  = mk(0, 0, 0,  32'h0,         2'b11, 5,  5,  0, 32'h1111_1111, 32'h1111_1111);
    tbl[6]  = mk(0, 0, 0,  32'h0,         2'b01, 5,  0,  0, 32'h1111_1111, 0);
    tbl[7]  = mk(0, 1, 5,  32'h2222_2222, 2'b11, 5,  5,  0, 32'h2222_2222, 32'h2222_2222);
    tbl[8]  = mk(0, 0, 0,  32'h0,         2'b11, 13, 3,  0, 0, 32'hA5A5_A5A5);
    tbl[9]  = mk(0, 1, 14, 32'hDEAD_BEEF, 2'b00, 0,  0,  1, 0, 0);
    tbl[10] = mk(0, 0, 0,  32'h0,         2'b11, 14, 2,  0, 0, 0);
    tbl[11] = mk(0, 1, 11, 32'hCAFE_F00D, 2'b11, 12, 11, 0, 0, 32'hCAFE_F00D);
    tbl[12] = mk(0, 0, 0,  32'h0,         2'b11, 11, 3,  0, 32'hCAFE_F00D, 32'hA5A5_A5A5);
    tbl[13] = mk(0, 0, 0,  32'h0,         2'b11, 3,  11, 0, 32'hA5A5_A5A5, 32'hCAFE_F00D);
    tbl[14] = mk(0, 1, 0,  32'h0123_4567, 2'b01, 0,  0,  0, 32'h0123_4567, 0);
    tbl[15] = mk(0, 1, 1,  32'hAAAA_0001, 2'b00, 0,  0,  0, 0, 0);
    tbl[16] = mk(0, 1, 2,  32'hAAAA_0002, 2'b01, 1,  0,  0, 32'hAAAA_0001, 0);
    tbl[17] = mk(0, 0, 0,  32'h0,         2'b11, 2,  1,  0, 32'hAAAA_0002, 32'hAAAA_0001);

    for (int k = 0; k < NUM_RD; k++) last_d[k] = '0;
    @(negedge clk);
    do_reset();

    // Reset release: INIT lasts DEPTH cycles, then every entry reads zero.
    init_walk();
    for (int a = 0; a < DEPTH; a++) begin
      step(mk(0, 0, 0, 0, 2'b11, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), 0, 0, 0));
    end

    // Table-driven write/read/bypass/OOR/drop vectors.
    for (int i = 0; i < 18; i++) step(tbl[i]);
    idle(2);

    // Fill every entry; each write is read back on the same edge (bypass).
    for (int a = 0; a < DEPTH; a++) begin
      step(mk(0, 1, ADDR_W'(a), 32'h5000_0000 | a, 2'b01, ADDR_W'(a), 0, 0,
              32'h5000_0000 | a, 0));
    end
    idle(1);
    for (int a = 0; a < DEPTH; a++) begin
      step(mk(0, 0, 0, 0, 2'b11, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), 0,
              32'h5000_0000 | a, 32'h5000_0000 | (DEPTH - 1 - a)));
    end

    // Soft clear together with a write: write dropped, table re-initialised.
    step(mk(1, 1, 4, 32'hFFFF_FFFF, 2'b00, 0, 0, 1, 0, 0));
    init_walk();
    for (int a = 0; a < DEPTH; a++) begin
      step(mk(0, 0, 0, 0, 2'b11, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), 0, 0, 0));
    end

    // Reset with reads in flight: nothing may emerge afterwards.
    step(mk(0, 1, 6, 32'h7777_7777, 2'b00, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 2'b11, 6, 6, 0, 32'h7777_7777, 32'h7777_7777));
    do_reset();
    init_walk();
    step(mk(0, 0, 0, 0, 2'b11, 6, 3, 0, 0, 0));
    idle(3);

    for (int k = 0; k < NUM_RD; k++) begin
      chk($sformatf("sb_drained ch%0d", k), 64'(sb_q[k].size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
